// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Optional per-requester grant counters are built when ALU_ARB_PERF_EN is defined.
module alu_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SEL_W = 10,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_in0,
    input  logic [WIDTH-1:0] req0_in1,
    input  logic [SEL_W-1:0] req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_in0,
    input  logic [WIDTH-1:0] req1_in1,
    input  logic [SEL_W-1:0] req1_sel,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_branch,
    output logic [WIDTH-1:0] alu_in0,
    output logic [WIDTH-1:0] alu_in1,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_branch
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [CNT_W-1:0] perf0_cnt,
    output logic [CNT_W-1:0] perf1_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             gnt_q, gnt_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] alu_in0_q, alu_in0_d;
    logic [WIDTH-1:0] alu_in1_q, alu_in1_d;
    logic [SEL_W-1:0] alu_sel_q, alu_sel_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_branch_q, rsp_branch_d;
    logic             win;
    logic             accept;

    // win=1 selects req1: it is the only valid requester, or both are valid and req1 did not win last
    assign win    = req1_valid && (!req0_valid || !last_grant_q);
    assign accept = (state_q == IDLE) && (req0_valid || req1_valid);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        rsp_valid_d  = rsp_valid_q;
        alu_in0_d    = alu_in0_q;
        alu_in1_d    = alu_in1_q;
        alu_sel_d    = alu_sel_q;
        rsp_data_d   = rsp_data_q;
        rsp_branch_d = rsp_branch_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    req0_ready   = !win;
                    req1_ready   = win;
                    alu_in0_d    = win ? req1_in0 : req0_in0;
                    alu_in1_d    = win ? req1_in1 : req0_in1;
                    alu_sel_d    = win ? req1_sel : req0_sel;
                    gnt_d        = win;
                    last_grant_d = win;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d   = alu_out;
                rsp_branch_d = alu_branch;
                rsp_valid_d  = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (gnt_q ? rsp1_ready : rsp0_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            rsp_valid_q  <= 1'b0;
            alu_in0_q    <= '0;
            alu_in1_q    <= '0;
            alu_sel_q    <= '0;
            rsp_data_q   <= '0;
            rsp_branch_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            rsp_valid_q  <= rsp_valid_d;
            alu_in0_q    <= alu_in0_d;
            alu_in1_q    <= alu_in1_d;
            alu_sel_q    <= alu_sel_d;
            rsp_data_q   <= rsp_data_d;
            rsp_branch_q <= rsp_branch_d;
        end
    end

    assign rsp0_valid = rsp_valid_q && !gnt_q;
    assign rsp1_valid = rsp_valid_q && gnt_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_branch = rsp_branch_q;
    assign alu_in0    = alu_in0_q;
    assign alu_in1    = alu_in1_q;
    assign alu_sel    = alu_sel_q;

`ifdef ALU_ARB_PERF_EN
    logic [CNT_W-1:0] perf0_cnt_q, perf0_cnt_d;
    logic [CNT_W-1:0] perf1_cnt_q, perf1_cnt_d;

    always_comb begin
        perf0_cnt_d = perf0_cnt_q;
        perf1_cnt_d = perf1_cnt_q;
        if (accept && !win) perf0_cnt_d = perf0_cnt_q + 1'b1;
        if (accept && win)  perf1_cnt_d = perf1_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf0_cnt_q <= '0;
            perf1_cnt_q <= '0;
        end else begin
            perf0_cnt_q <= perf0_cnt_d;
            perf1_cnt_q <= perf1_cnt_d;
        end
    end

    assign perf0_cnt = perf0_cnt_q;
    assign perf1_cnt = perf1_cnt_q;
`endif

endmodule
